conv_7x7_pass_scheduler: RTL

- Sequences one full 7x7 convolution layer through the existing conv pipeline (loop-data, conv, channel adder, align).
- Runs one pass per output channel:
  - streams that channel's KERNEL*KERNEL*CHANNEL_NUM_IN weights from weight memory;
  - streams the whole input image (all input channels) from pixel memory;
  - waits until the pipeline has returned OUT_SIZE results.
- Repeats for CHANNEL_NUM_OUT channels, then signals done. Sits between layer memories and the conv pipeline top.

---
 rtl/conv_7x7_pass_scheduler_if.sv | 47 ++++
 rtl/conv_7x7_pass_scheduler.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/conv_7x7_pass_scheduler_if.sv
// Handshake/memory/pipeline bundle for conv_7x7_pass_scheduler.
// Carries perf_cycles only when CONV7_SCHED_PERF_EN is defined.
interface conv_7x7_pass_scheduler_if #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 20,
  parameter int unsigned CHANNEL_NUM_OUT = 64
);
  localparam int unsigned ChW = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;

  logic                  start;
  logic                  busy;
  logic                  done;
  logic [ChW-1:0]        ch_idx;
  logic                  w_rd_en;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  valid_weight_out;
  logic [DATA_WIDTH-1:0] weight_out;
  logic                  p_rd_en;
  logic [ADDR_WIDTH-1:0] p_rd_addr;
  logic [DATA_WIDTH-1:0] p_rd_data;
  logic                  valid_pxl_out;
  logic [DATA_WIDTH-1:0] pxl_out;
  logic                  valid_res_in;
  logic                  err;
`ifdef CONV7_SCHED_PERF_EN
  logic [31:0]           perf_cycles;
`endif

  modport master (
`ifdef CONV7_SCHED_PERF_EN
    input  perf_cycles,
`endif
    output start, w_rd_data, p_rd_data, valid_res_in,
    input  busy, done, ch_idx, w_rd_en, w_rd_addr, valid_weight_out, weight_out,
    input  p_rd_en, p_rd_addr, valid_pxl_out, pxl_out, err
  );

  modport slave (
`ifdef CONV7_SCHED_PERF_EN
    output perf_cycles,
`endif
    input  start, w_rd_data, p_rd_data, valid_res_in,
    output busy, done, ch_idx, w_rd_en, w_rd_addr, valid_weight_out, weight_out,
    output p_rd_en, p_rd_addr, valid_pxl_out, pxl_out, err
  );
endinterface

// File: rtl/conv_7x7_pass_scheduler.sv
// Runs one 7x7 conv layer as CHANNEL_NUM_OUT passes: weights, then image, then drain results.
// Optional busy-cycle counter on perf_cycles when CONV7_SCHED_PERF_EN is defined.
module conv_7x7_pass_scheduler #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned KERNEL          = 7,
  parameter int unsigned CHANNEL_NUM_IN  = 3,
  parameter int unsigned CHANNEL_NUM_OUT = 64,
  parameter int unsigned IMAGE_SIZE      = 50176,
  parameter int unsigned OUT_SIZE        = 12544,
  parameter int unsigned ADDR_WIDTH      = 20
) (
  input logic                    clk,
  input logic                    reset,
  conv_7x7_pass_scheduler_if.slave bus
);
  localparam int unsigned ChW = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;
  localparam int unsigned ResW = $clog2(OUT_SIZE + 1);
  localparam logic [ADDR_WIDTH-1:0] WnLast = ADDR_WIDTH'(KERNEL * KERNEL * CHANNEL_NUM_IN - 1);
  localparam logic [ADDR_WIDTH-1:0] PnLast = ADDR_WIDTH'(IMAGE_SIZE * CHANNEL_NUM_IN - 1);
  localparam logic [ResW-1:0]       ResFull = ResW'(OUT_SIZE);
  localparam logic [ResW-1:0]       ResLast = ResW'(OUT_SIZE - 1);
  localparam logic [ChW-1:0]        ChLast  = ChW'(CHANNEL_NUM_OUT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_W = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] r_w_addr;
  logic [ADDR_WIDTH-1:0] r_p_addr;
  logic [ResW-1:0]       r_res_cnt;
  logic [ChW-1:0]        r_ch;
  logic                  r_err;
  logic                  r_vw;
  logic                  r_vp;
  logic [DATA_WIDTH-1:0] r_wo;
  logic [DATA_WIDTH-1:0] r_po;

  logic w_in_pass;
  logic w_res_full;
  logic w_pass_done;

  assign w_in_pass   = (r_state == S_LOAD_W) || (r_state == S_STREAM) || (r_state == S_DRAIN);
  assign w_res_full  = (r_res_cnt == ResFull);
  // The completing result and the DRAIN exit share one edge.
  assign w_pass_done = w_res_full || ((r_res_cnt == ResLast) && bus.valid_res_in);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_w_addr  <= '0;
      r_p_addr  <= '0;
      r_res_cnt <= '0;
      r_ch      <= '0;
      r_err     <= 1'b0;
      r_vw      <= 1'b0;
      r_vp      <= 1'b0;
      r_wo      <= '0;
      r_po      <= '0;
    end else begin
      r_vw <= (r_state == S_LOAD_W);
      r_vp <= (r_state == S_STREAM);
      if (r_state == S_LOAD_W) r_wo <= bus.w_rd_data;
      if (r_state == S_STREAM) r_po <= bus.p_rd_data;

      if (bus.valid_res_in) begin
        if (!w_in_pass || w_res_full) r_err <= 1'b1;
        else                          r_res_cnt <= r_res_cnt + ResW'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state   <= S_LOAD_W;
            r_ch      <= '0;
            r_err     <= bus.valid_res_in;
            r_w_addr  <= '0;
            r_cnt     <= '0;
            r_res_cnt <= '0;
          end
        end
        S_LOAD_W: begin
          if (r_cnt == WnLast) begin
            r_cnt    <= '0;
            r_p_addr <= '0;
            r_state  <= S_STREAM;
          end else begin
            r_cnt    <= r_cnt + ADDR_WIDTH'(1);
            r_w_addr <= r_w_addr + ADDR_WIDTH'(1);
          end
        end
        S_STREAM: begin
          if (r_p_addr == PnLast) r_state <= S_DRAIN;
          else                    r_p_addr <= r_p_addr + ADDR_WIDTH'(1);
        end
        S_DRAIN: begin
          if (w_pass_done) begin
            if (r_ch == ChLast) begin
              r_state <= S_DONE;
            end else begin
              // Weight blocks are contiguous, so the next base is last address + 1.
              r_ch      <= r_ch + ChW'(1);
              r_w_addr  <= r_w_addr + ADDR_WIDTH'(1);
              r_cnt     <= '0;
              r_res_cnt <= '0;
              r_state   <= S_LOAD_W;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy             = (r_state != S_IDLE);
  assign bus.done             = (r_state == S_DONE);
  assign bus.ch_idx           = r_ch;
  assign bus.w_rd_en          = (r_state == S_LOAD_W);
  assign bus.w_rd_addr        = r_w_addr;
  assign bus.p_rd_en          = (r_state == S_STREAM);
  assign bus.p_rd_addr        = r_p_addr;
  assign bus.valid_weight_out = r_vw;
  assign bus.weight_out       = r_wo;
  assign bus.valid_pxl_out    = r_vp;
  assign bus.pxl_out          = r_po;
  assign bus.err              = r_err;

`ifdef CONV7_SCHED_PERF_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_perf <= '0;
    end else if ((r_state == S_IDLE) && bus.start) begin
      r_perf <= '0;
    end else if (bus.busy && (r_perf != 32'hFFFF_FFFF)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign bus.perf_cycles = r_perf;
`endif
endmodule
